// File: rtl/particle_store.sv
// Collection stage for the dual-lane particle pusher. Pairs are buffered in a small FIFO and
// written to particle memory at sequential addresses; frame_done pulses after NUM_PAIRS writes.
module particle_store #(
    parameter int unsigned PWIDTH    = 64,
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned NUM_PAIRS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  valid_in,
    input  logic [2*PWIDTH-1:0]   particle_in,
    input  logic                  mem_ready,
    output logic                  mem_wen,
    output logic [AWIDTH-1:0]     mem_waddr,
    output logic [2*PWIDTH-1:0]   mem_wdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [AWIDTH:0]       pair_count
);

    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam logic [AWIDTH:0]   LP_NUM   = (AWIDTH+1)'(NUM_PAIRS);
    localparam logic [AWIDTH:0]   LP_LAST  = LP_NUM - 1'b1;
    localparam logic [PTR_W:0]    LP_DEPTH = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [2*PWIDTH-1:0]   r_fifo [DEPTH];
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic [AWIDTH:0]       r_accepted;
    logic [AWIDTH:0]       r_pair_count;
    logic                  r_overflow;

    logic [PTR_W:0]        w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_arm;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_count == LP_DEPTH);

    assign w_pop  = (r_state == StRun) && !w_empty && mem_ready;
    assign w_push = (r_state == StRun) && valid_in && (r_accepted < LP_NUM)
                    && (!w_full || w_pop);
    assign w_drop = valid_in && (((r_state == StRun) && !w_push) || (r_state == StDone));
    assign w_last = w_pop && (r_pair_count == LP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_arm        = 1'b0;
        case (r_state)
            StIdle: begin
                if (frame_start) begin
                    w_state_next = StRun;
                    w_arm        = 1'b1;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_accepted   <= '0;
            r_pair_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_arm) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_accepted   <= '0;
            r_pair_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr     <= r_wptr + 1'b1;
                r_accepted <= r_accepted + 1'b1;
            end
            if (w_pop) begin
                r_rptr       <= r_rptr + 1'b1;
                r_pair_count <= r_pair_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the empty flag masks stale entries on the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[PTR_W-1:0]] <= particle_in;
        end
    end

    assign mem_wen    = w_pop;
    assign mem_waddr  = r_pair_count[AWIDTH-1:0];
    assign mem_wdata  = w_empty ? '0 : r_fifo[r_rptr[PTR_W-1:0]];
    assign busy       = (r_state != StIdle);
    assign frame_done = (r_state == StDone);
    assign overflow   = r_overflow;
    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_particle_store.sv
// Self-checking bench for particle_store: randomized pairs checked cycle by cycle against a
// queue-based model of the frame collection rules.
module tb_particle_store;

    localparam int unsigned PW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned DP = 8;
    localparam int unsigned NP = 12;
    localparam int unsigned OW = 2*AW + 5 + 2*PW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            frame_start = 1'b0;
    logic            valid_in = 1'b0;
    logic [2*PW-1:0] particle_in = '0;
    logic            mem_ready = 1'b0;
    logic            mem_wen;
    logic [AW-1:0]   mem_waddr;
    logic [2*PW-1:0] mem_wdata;
    logic            busy;
    logic            frame_done;
    logic            overflow;
    logic [AW:0]     pair_count;
    logic [OW-1:0]   obs_all;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    particle_store #(
        .PWIDTH   (PW),
        .AWIDTH   (AW),
        .DEPTH    (DP),
        .NUM_PAIRS(NP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .valid_in   (valid_in),
        .particle_in(particle_in),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .pair_count (pair_count)
    );

    assign obs_all = {mem_wen, mem_waddr, busy, frame_done, overflow, pair_count,
                      (mem_wen ? mem_wdata : {(2*PW){1'b0}})};

    // Model: 0 = idle, 1 = collecting, 2 = frame-end cycle.
    logic [2*PW-1:0] m_q[$];
    int              m_acc;
    int              m_pc;
    bit              m_ov;
    int              m_mode;

    always @(posedge clk or negedge rst) begin : model
        bit pop;
        if (!rst) begin
            m_q.delete();
            m_acc = 0; m_pc = 0; m_ov = 0; m_mode = 0;
        end else begin
            pop = (m_mode == 1) && (m_q.size() != 0) && mem_ready;
            case (m_mode)
                0: if (frame_start) begin
                    m_q.delete();
                    m_acc = 0; m_pc = 0; m_ov = 0; m_mode = 1;
                end
                1: begin
                    if (pop) begin
                        void'(m_q.pop_front());
                        m_pc++;
                    end
                    if (valid_in) begin
                        if (m_acc < NP && m_q.size() < DP) begin
                            m_q.push_back(particle_in);
                            m_acc++;
                        end else begin
                            m_ov = 1;
                        end
                    end
                    if (m_pc == NP) m_mode = 2;
                end
                default: begin
                    if (valid_in) m_ov = 1;
                    m_mode = 0;
                end
            endcase
        end
    end

    function automatic logic [OW-1:0] exp_all();
        logic            wen;
        logic [2*PW-1:0] d;
        wen = rst && (m_mode == 1) && (m_q.size() != 0) && mem_ready;
        d   = wen ? m_q[0] : '0;
        return {wen, AW'(m_pc), m_mode != 0, m_mode == 2, m_ov, (AW+1)'(m_pc), d};
    endfunction

    task automatic drive(input bit fs, input bit v, input bit rdy);
        @(negedge clk);
        frame_start = fs;
        valid_in    = v;
        mem_ready   = rdy;
        particle_in = (2*PW)'($urandom);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (obs_all !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", obs_all);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int writes = 0;
        int dones  = 0;
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NP + 8; i++) begin
            // Tail cycles present valid_in while idle: must be ignored.
            drive(1'b0, (i < NP) || (i > NP + 3), 1'b1);
            writes += int'(mem_wen);
            dones  += int'(frame_done);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL basic cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
        n_vec++;
        if (writes != NP || dones != 1 || overflow !== 1'b0 || pair_count !== (AW+1)'(NP)) begin
            n_err++;
            $display("FAIL basic_totals: writes=%0d dones=%0d ov=%b pc=%0d want %0d/1/0/%0d",
                     writes, dones, overflow, pair_count, NP, NP);
        end
    endtask

    task automatic test_stall_fill();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DP + 1; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL stall_fill cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL stall_overflow: got %b want 1", overflow);
        end
        for (int i = 0; i < 40 && (m_mode != 0 || busy); i++) begin
            drive(1'b0, i >= DP, 1'b1);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL stall_drain cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_full_pop();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DP; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        n_vec++;
        if (obs_all !== exp_all() || mem_wen !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_cycle: got %h want %h", obs_all, exp_all());
        end
        // Occupancy must still be DEPTH, so a stalled push now is dropped.
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_pop_no_ovf: got %b want 0", overflow);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_occupancy: ovf got %b want 1", overflow);
        end
        for (int i = 0; i < 40 && (m_mode != 0 || busy); i++) begin
            drive(1'b0, 1'b1, 1'b1);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL full_pop_drain cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_excess_idle();
        int writes = 0;
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NP + 6; i++) begin
            drive(1'b0, i <= NP, 1'b1);
            writes += int'(mem_wen);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL excess cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
        n_vec++;
        if (writes != NP || overflow !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL excess_totals: writes=%0d ov=%b busy=%b want %0d/1/0",
                     writes, overflow, busy, NP);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20 && m_pc < 2; i++) drive(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (obs_all !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h want 0", obs_all);
        end
        drive(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (obs_all !== '0) begin
            n_err++;
            $display("FAIL reset_mid_held: got %h want 0", obs_all);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40 && (m_mode != 0 || busy); i++) begin
            drive(1'b0, 1'b1, 1'b1);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL reset_mid_refill cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_ignored_fs();
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40 && (m_mode != 0 || busy); i++) begin
            // frame_start asserted on every third cycle of RUN and on DONE.
            drive((i % 3 == 2) || (m_mode == 2), i < NP, $urandom_range(0, 3) != 0);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL ignored_fs cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive((m_mode == 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0);
            n_vec++;
            if (obs_all !== exp_all()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_fill();
        test_full_pop();
        test_excess_idle();
        test_reset_mid();
        test_ignored_fs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
